// File: rtl/pla_duke2_capture_if.sv
// Handshake bundle between the duke2 PLA evaluator, the capture stage and its consumer.
// The slave view belongs to the capture stage; the master view to whoever drives and drains it.
interface pla_duke2_capture_if;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] in_x;
    logic [28:0] in_z;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] out_x;
    logic [28:0] out_z;
    logic        out_par;

    modport slave  (input  in_valid, in_x, in_z, out_ready,
                    output in_ready, out_valid, out_x, out_z, out_par);
    modport master (output in_valid, in_x, in_z, out_ready,
                    input  in_ready, out_valid, out_x, out_z, out_par);
endinterface

// File: rtl/pla_duke2_capture.sv
// Capture stage behind the duke2 PLA: buffers (x, z) vectors in a small FIFO
// and keeps sticky per-output high/low coverage plus a saturating vector count.
module pla_duke2_capture #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pla_duke2_capture_if.slave     bus,
    input  logic                   clr,
    output logic [28:0]            seen_hi,
    output logic [28:0]            seen_lo,
    output logic [CNT_W-1:0]       vec_count,
    output logic                   all_cov
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [21:0]      x_mem [DEPTH];
    logic [28:0]      z_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [21:0]      last_x;
    logic [28:0]      last_z;
    logic [21:0]      head_x;
    logic [28:0]      head_z;
    logic             acc, rel;

    logic [28:0]      seen_hi_n, seen_lo_n;
    logic [CNT_W-1:0] vec_count_n;

    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != '0);
    assign acc = bus.in_valid & bus.in_ready;
    assign rel = bus.out_valid & bus.out_ready;

    // Storage is only written on accept, so idle-bus X never lands in it.
    always_ff @(posedge clk) begin
        if (acc) begin
            x_mem[wr_ptr] <= bus.in_x;
            z_mem[wr_ptr] <= bus.in_z;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_x <= '0;
            last_z <= '0;
        end else begin
            if (acc) wr_ptr <= wr_ptr + 1'b1;
            if (rel) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_x <= x_mem[rd_ptr];
                last_z <= z_mem[rd_ptr];
            end
            case ({acc, rel})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The last released entry is shown while empty, so outputs hold their value.
    assign head_x      = bus.out_valid ? x_mem[rd_ptr] : last_x;
    assign head_z      = bus.out_valid ? z_mem[rd_ptr] : last_z;
    assign bus.out_x   = head_x;
    assign bus.out_z   = head_z;
    assign bus.out_par = ^head_z;

    always_comb begin
        seen_hi_n   = clr ? '0 : seen_hi;
        seen_lo_n   = clr ? '0 : seen_lo;
        vec_count_n = clr ? '0 : vec_count;
        if (acc) begin
            seen_hi_n |= bus.in_z;
            seen_lo_n |= ~bus.in_z;
            if (vec_count_n != '1) vec_count_n = vec_count_n + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_hi   <= '0;
            seen_lo   <= '0;
            vec_count <= '0;
            all_cov   <= 1'b0;
        end else begin
            seen_hi   <= seen_hi_n;
            seen_lo   <= seen_lo_n;
            vec_count <= vec_count_n;
            all_cov   <= (&seen_hi_n) & (&seen_lo_n);
        end
    end
endmodule
